// File: rtl/xintf_pkg.sv
// ============================================================================
// Module      : xintf_pkg
// Description : Shared types and constants for the XINTF DPBRAM frame reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xintf_pkg;

    // Width of the trailing frame checksum and of one DPBRAM halfword
    localparam int CSUM_W = 16;
    localparam int HW_W   = 16;

    // Frame reader sequencing states
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_LO    = 4'd1,
        WAIT_LO  = 4'd2,
        RD_HI    = 4'd3,
        WAIT_HI  = 4'd4,
        PUSH     = 4'd5,
        RD_SUM   = 4'd6,
        WAIT_SUM = 4'd7,
        DONE     = 4'd8
    } state_t;

    // The checksum halfword sits directly after the 2*num_words data halfwords
    function automatic int unsigned csum_addr(input int unsigned base,
                                              input int unsigned num_words);
        return base + 2 * num_words;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xintf_dpbram_frame_reader.sv
// ============================================================================
// Module      : xintf_dpbram_frame_reader
// Description : Scans a fixed halfword frame from DPBRAM port 1, packs
//               even/odd halfword pairs into 32-bit stream beats and checks
//               the trailing 16-bit additive checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xintf_dpbram_frame_reader
    import xintf_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_WORDS  = 32,
    parameter int BASE_ADDR  = 0,
    parameter int READ_LAT   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_frame_err,
    output logic [15:0]           o_frame_cnt,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_ce,
    output logic                  o_bram_we,
    output logic [15:0]           o_bram_din,
    input  logic [15:0]           i_bram_dout,
    output logic [7:0]            o_m_addr,
    output logic [31:0]           o_m_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic                  o_m_last
);

    // Frame must fit in the BRAM and word index must fit in 8 bits
    if ((BASE_ADDR + 2 * NUM_WORDS) > ((1 << ADDR_WIDTH) - 1) || NUM_WORDS > 256 ||
        NUM_WORDS < 1 || READ_LAT < 1 || READ_LAT > 3) begin : g_param_check
        $fatal(1, "xintf_dpbram_frame_reader: illegal parameter combination");
    end

    localparam logic [ADDR_WIDTH-1:0] c_base      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_csum_addr = ADDR_WIDTH'(csum_addr(BASE_ADDR, NUM_WORDS));
    localparam logic [7:0]            c_last_k    = 8'(NUM_WORDS - 1);
    localparam logic [1:0]            c_lat_init  = 2'(READ_LAT - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_k;
    logic [1:0]              r_lat;
    logic [HW_W-1:0]         r_lo;
    logic [HW_W-1:0]         r_hi;
    logic [CSUM_W-1:0]       r_acc;
    logic [CSUM_W-1:0]       r_csum;
    logic                    r_frame_err;
    logic [15:0]             r_frame_cnt;
    logic                    w_lat_done;
    logic                    w_is_last;
    logic [ADDR_WIDTH-1:0]   w_lo_addr;

    assign w_lat_done  = (r_lat == 2'd0);
    assign w_is_last   = (r_k == c_last_k);
    assign w_lo_addr   = c_base + ADDR_WIDTH'({r_k, 1'b0});

    assign o_bram_we   = 1'b0;
    assign o_bram_din  = 16'h0000;
    assign o_frame_err = r_frame_err;
    assign o_frame_cnt = r_frame_cnt;

    // State register; async reset drops ce/valid the instant it asserts
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next      = r_state;
        o_bram_ce   = 1'b0;
        o_bram_addr = '0;
        o_m_valid   = 1'b0;
        o_m_addr    = 8'h00;
        o_m_data    = 32'h0000_0000;
        o_m_last    = 1'b0;
        o_done      = 1'b0;
        o_busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = RD_LO;
                end
            end
            RD_LO: begin
                o_bram_ce   = 1'b1;
                o_bram_addr = w_lo_addr;
                w_next      = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_lat_done) begin
                    w_next = RD_HI;
                end
            end
            RD_HI: begin
                o_bram_ce   = 1'b1;
                o_bram_addr = w_lo_addr + ADDR_WIDTH'(1);
                w_next      = WAIT_HI;
            end
            WAIT_HI: begin
                if (w_lat_done) begin
                    w_next = PUSH;
                end
            end
            PUSH: begin
                o_m_valid = 1'b1;
                o_m_addr  = r_k;
                o_m_data  = {r_hi, r_lo};
                o_m_last  = w_is_last;
                if (i_m_ready) begin
                    w_next = w_is_last ? RD_SUM : RD_LO;
                end
            end
            RD_SUM: begin
                o_bram_ce   = 1'b1;
                o_bram_addr = c_csum_addr;
                w_next      = WAIT_SUM;
            end
            WAIT_SUM: begin
                if (w_lat_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Word index, read-latency countdown, halfword capture and checksum
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_k         <= 8'h00;
            r_lat       <= 2'd0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_acc       <= '0;
            r_csum      <= '0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_k         <= 8'h00;
                        r_acc       <= '0;
                        r_frame_err <= 1'b0;
                    end
                end
                RD_LO, RD_HI, RD_SUM: begin
                    r_lat <= c_lat_init;
                end
                WAIT_LO: begin
                    if (w_lat_done) begin
                        r_lo  <= i_bram_dout;
                        r_acc <= r_acc + i_bram_dout;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                WAIT_HI: begin
                    if (w_lat_done) begin
                        r_hi  <= i_bram_dout;
                        r_acc <= r_acc + i_bram_dout;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                PUSH: begin
                    if (i_m_ready && !w_is_last) begin
                        r_k <= r_k + 8'd1;
                    end
                end
                WAIT_SUM: begin
                    if (w_lat_done) begin
                        r_csum <= i_bram_dout;
                    end else begin
                        r_lat <= r_lat - 2'd1;
                    end
                end
                DONE: begin
                    r_frame_err <= (r_acc != r_csum);
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xintf_dpbram_frame_reader.sv
// ============================================================================
// Module      : tb_xintf_dpbram_frame_reader
// Description : Directed, table-driven bench for the DPBRAM frame reader.
//               Instance 1 uses READ_LAT=1, instance 2 uses READ_LAT=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xintf_dpbram_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        ready1 = 1'b1;
    logic        ready2 = 1'b1;
    logic [15:0] mem [0:511];

    // DUT 1 signals (READ_LAT = 1)
    logic        busy1, done1, err1, ce1, we1, valid1, last1;
    logic [15:0] cnt1, din1, dout1;
    logic [8:0]  baddr1;
    logic [7:0]  maddr1;
    logic [31:0] mdata1;

    // DUT 2 signals (READ_LAT = 2)
    logic        busy2, done2, err2, ce2, we2, valid2, last2;
    logic [15:0] cnt2, din2, dout2;
    logic [8:0]  baddr2;
    logic [7:0]  maddr2;
    logic [31:0] mdata2;

    xintf_dpbram_frame_reader #(.ADDR_WIDTH(9), .NUM_WORDS(32), .BASE_ADDR(0), .READ_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_frame_err(err1), .o_frame_cnt(cnt1), .o_bram_addr(baddr1), .o_bram_ce(ce1),
        .o_bram_we(we1), .o_bram_din(din1), .i_bram_dout(dout1), .o_m_addr(maddr1),
        .o_m_data(mdata1), .o_m_valid(valid1), .i_m_ready(ready1), .o_m_last(last1)
    );

    xintf_dpbram_frame_reader #(.ADDR_WIDTH(9), .NUM_WORDS(32), .BASE_ADDR(0), .READ_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_frame_err(err2), .o_frame_cnt(cnt2), .o_bram_addr(baddr2), .o_bram_ce(ce2),
        .o_bram_we(we2), .o_bram_din(din2), .i_bram_dout(dout2), .o_m_addr(maddr2),
        .o_m_data(mdata2), .o_m_valid(valid2), .i_m_ready(ready2), .o_m_last(last2)
    );

    // BRAM models: read data is valid only in the exact cycle READ_LAT after ce
    logic        v1a = 1'b0, v2a = 1'b0, v2b = 1'b0;
    logic [15:0] d1a = 16'h0, d2a = 16'h0, d2b = 16'h0;
    always @(posedge clk) begin
        v1a <= ce1;
        d1a <= mem[baddr1];
        v2a <= ce2;
        d2a <= mem[baddr2];
        v2b <= v2a;
        d2b <= d2a;
    end
    assign dout1 = v1a ? d1a : 16'hDEAD;
    assign dout2 = v2b ? d2b : 16'hDEAD;

    // Monitors: cumulative counters and accepted-beat logs
    int          ce_cnt1 = 0, done_cnt1 = 0, nb1 = 0, last_cnt1 = 0, busy_cyc1 = 0;
    int          ce_cnt2 = 0, done_cnt2 = 0, nb2 = 0, last_cnt2 = 0, busy_cyc2 = 0;
    logic [7:0]  ba1 [0:511];
    logic [31:0] bd1 [0:511];
    logic        bl1 [0:511];
    logic [7:0]  ba2 [0:511];
    logic [31:0] bd2 [0:511];
    logic        bl2 [0:511];

    always @(negedge clk) begin
        if (ce1)   ce_cnt1++;
        if (done1) done_cnt1++;
        if (busy1) busy_cyc1++;
        if (valid1 && ready1 && nb1 < 512) begin
            ba1[nb1] = maddr1;
            bd1[nb1] = mdata1;
            bl1[nb1] = last1;
            if (last1) last_cnt1++;
            nb1++;
        end
    end

    always @(negedge clk) begin
        if (ce2)   ce_cnt2++;
        if (done2) done_cnt2++;
        if (busy2) busy_cyc2++;
        if (valid2 && ready2 && nb2 < 512) begin
            ba2[nb2] = maddr2;
            bd2[nb2] = mdata2;
            bl2[nb2] = last2;
            if (last2) last_cnt2++;
            nb2++;
        end
    end

    // Scoreboard
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Beat vector table: {beat index, expected addr, data, last}
    typedef struct {
        int          beat;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } vec_t;
    vec_t vt [5];

    task automatic check_beats(input int which, input int base, input string tag);
        int bad;
        logic [7:0]  a;
        logic [31:0] d;
        logic        l;
        for (int i = 0; i < 5; i++) begin
            a = (which == 1) ? ba1[base + vt[i].beat] : ba2[base + vt[i].beat];
            d = (which == 1) ? bd1[base + vt[i].beat] : bd2[base + vt[i].beat];
            l = (which == 1) ? bl1[base + vt[i].beat] : bl2[base + vt[i].beat];
            check($sformatf("%s_beat%0d_addr", tag, vt[i].beat), 64'(a), 64'(vt[i].addr));
            check($sformatf("%s_beat%0d_data", tag, vt[i].beat), 64'(d), 64'(vt[i].data));
            check($sformatf("%s_beat%0d_last", tag, vt[i].beat), 64'(l), 64'(vt[i].last));
        end
        // Every beat against the arithmetic model of the test pattern
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            a = (which == 1) ? ba1[base + k] : ba2[base + k];
            d = (which == 1) ? bd1[base + k] : bd2[base + k];
            l = (which == 1) ? bl1[base + k] : bl2[base + k];
            if (a !== 8'(k) || d !== {16'(2 * k + 2), 16'(2 * k + 1)} || l !== (k == 31)) bad++;
        end
        check({tag, "_all_beats_bad"}, 64'(bad), 64'd0);
    endtask

    task automatic pulse_start1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic pulse_start2;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
    endtask

    task automatic wait_done1(input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done1) begin ok = 1'b1; break; end
        end
        if (!ok) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_done2(input int budget, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done2) begin ok = 1'b1; break; end
        end
        if (!ok) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int b_nb, b_ce, b_done, b_last, b_busy;
        int stall_bad, stall_seen;
        bit found;

        vt[0] = '{beat: 0,  addr: 8'd0,  data: 32'h0002_0001, last: 1'b0};
        vt[1] = '{beat: 1,  addr: 8'd1,  data: 32'h0004_0003, last: 1'b0};
        vt[2] = '{beat: 5,  addr: 8'd5,  data: 32'h000C_000B, last: 1'b0};
        vt[3] = '{beat: 30, addr: 8'd30, data: 32'h003E_003D, last: 1'b0};
        vt[4] = '{beat: 31, addr: 8'd31, data: 32'h0040_003F, last: 1'b1};

        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 64; i++)  mem[i] = 16'(i + 1);
        mem[64] = 16'h0820;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_done_err", {61'd0, busy1, done1, err1}, 64'd0);
        check("rst_frame_cnt", 64'(cnt1), 64'd0);
        check("rst_ce_valid_last", {61'd0, ce1, valid1, last1}, 64'd0);
        check("rst_we_din", {47'd0, we1, din1}, 64'd0);
        check("rst_addrs_data", {23'd0, baddr1, maddr1, mdata1}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // ---------------- test 1: clean frame, READ_LAT=1 ----------------
        #1;
        b_nb = nb1; b_ce = ce_cnt1; b_done = done_cnt1; b_last = last_cnt1; b_busy = busy_cyc1;
        pulse_start1;
        check("t1_busy_after_start", 64'(busy1), 64'd1);
        wait_done1(400, "t1");
        @(posedge clk); #1;
        check("t1_frame_err", 64'(err1), 64'd0);
        check("t1_frame_cnt", 64'(cnt1), 64'd1);
        check("t1_beats", 64'(nb1 - b_nb), 64'd32);
        check("t1_ce_cycles", 64'(ce_cnt1 - b_ce), 64'd65);
        check("t1_done_pulses", 64'(done_cnt1 - b_done), 64'd1);
        check("t1_last_beats", 64'(last_cnt1 - b_last), 64'd1);
        check("t1_busy_cycles", 64'(busy_cyc1 - b_busy), 64'd163);
        check("t1_idle_busy", 64'(busy1), 64'd0);
        check_beats(1, b_nb, "t1");

        // ---------------- test 2: bad checksum then good ----------------
        mem[64] = 16'h0821;
        pulse_start1;
        wait_done1(400, "t2a");
        @(posedge clk); #1;
        check("t2_err_set", 64'(err1), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t2_err_held", 64'(err1), 64'd1);
        check("t2_frame_cnt_bad", 64'(cnt1), 64'd2);
        mem[64] = 16'h0820;
        pulse_start1;
        check("t2_err_cleared_at_start", 64'(err1), 64'd0);
        wait_done1(400, "t2b");
        @(posedge clk); #1;
        check("t2_err_good", 64'(err1), 64'd0);
        check("t2_frame_cnt_good", 64'(cnt1), 64'd3);

        // ---------------- test 3: 10-cycle stall at beat 5 ----------------
        b_nb = nb1; b_ce = ce_cnt1;
        pulse_start1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid1 && maddr1 == 8'd4) begin found = 1'b1; break; end
        end
        check("t3_reach_beat4", 64'(found), 64'd1);
        @(posedge clk); #1 ready1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid1) begin found = 1'b1; break; end
        end
        check("t3_reach_beat5", 64'(found), 64'd1);
        stall_bad = 0;
        stall_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            stall_seen++;
            if (!valid1 || maddr1 !== 8'd5 || mdata1 !== 32'h000C_000B || last1 || ce1) stall_bad++;
        end
        check("t3_stall_stable_bad", 64'(stall_bad), 64'd0);
        @(posedge clk); #1 ready1 = 1'b1;
        wait_done1(400, "t3");
        @(posedge clk); #1;
        check("t3_beats", 64'(nb1 - b_nb), 64'd32);
        check("t3_ce_cycles", 64'(ce_cnt1 - b_ce), 64'd65);
        check("t3_err", 64'(err1), 64'd0);
        check_beats(1, b_nb, "t3");

        // ---------------- test 4: ignored start pulses ----------------
        b_nb = nb1; b_done = done_cnt1;
        pulse_start1;
        repeat (18) @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        wait_done1(400, "t4");
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t4_not_restarted", 64'(busy1), 64'd0);
        check("t4_beats", 64'(nb1 - b_nb), 64'd32);
        check("t4_done_pulses", 64'(done_cnt1 - b_done), 64'd1);
        check("t4_frame_cnt", 64'(cnt1), 64'd5);

        // ---------------- test 5: reset during beat 10 ----------------
        pulse_start1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid1 && maddr1 == 8'd10) begin found = 1'b1; break; end
        end
        check("t5_reach_beat10", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_ce_valid_busy_low", {61'd0, ce1, valid1, busy1}, 64'd0);
        check("t5_frame_cnt_cleared", 64'(cnt1), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        b_nb = nb1; b_ce = ce_cnt1;
        pulse_start1;
        wait_done1(400, "t5");
        @(posedge clk); #1;
        check("t5_beats", 64'(nb1 - b_nb), 64'd32);
        check("t5_ce_cycles", 64'(ce_cnt1 - b_ce), 64'd65);
        check("t5_err", 64'(err1), 64'd0);
        check("t5_frame_cnt", 64'(cnt1), 64'd1);
        check_beats(1, b_nb, "t5");

        // ---------------- test 6: READ_LAT=2 instance ----------------
        b_nb = nb2; b_ce = ce_cnt2; b_done = done_cnt2; b_last = last_cnt2; b_busy = busy_cyc2;
        pulse_start2;
        wait_done2(600, "t6");
        @(posedge clk); #1;
        check("t6_beats", 64'(nb2 - b_nb), 64'd32);
        check("t6_ce_cycles", 64'(ce_cnt2 - b_ce), 64'd65);
        check("t6_done_pulses", 64'(done_cnt2 - b_done), 64'd1);
        check("t6_last_beats", 64'(last_cnt2 - b_last), 64'd1);
        check("t6_busy_cycles", 64'(busy_cyc2 - b_busy), 64'd228);
        check("t6_err", 64'(err2), 64'd0);
        check("t6_frame_cnt", 64'(cnt2), 64'd1);
        check_beats(2, b_nb, "t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
